parallel_in_serial_out_tx: RTL and testbench

//  Transmit end of the 4-bit shift-register serial link. Accepts a parallel word

---
 rtl/piso_pkg.sv | 32 +++
 rtl/parallel_in_serial_out_tx.sv | 124 ++++++++++++
 tb/tb_parallel_in_serial_out_tx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out link transmitter:
// FSM state encodings, default word width and the bit-counter width helper.
package piso_pkg;

    localparam int PISO_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // A one-bit counter is still needed for the degenerate two-bit word.
    function automatic int cntW(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

    // Even parity over a captured word.
    function automatic logic evenParity(input logic [PISO_WIDTH*8-1:0] word, input int width);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < width; i++) begin
            acc = acc ^ word[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/parallel_in_serial_out_tx.sv
// Transmit end of the shift-register serial link: Load/Ready word capture,
// ShiftEn-paced serialisation. Optional trailing even-parity bit via `PARITY_EN.
module parallel_in_serial_out_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] ParallelIn,
    input  logic             Load,
    output logic             Ready,
    input  logic             ShiftEn,
    output logic             ShiftOut,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = cntW(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] shiftReg_r;
    logic [CW-1:0]    bitCnt_r;
    logic             done_r;
    logic [WIDTH-1:0] shiftNext_s;
    logic             head_s;
`ifdef PARITY_EN
    logic             parity_r;
`endif

    // Next shift-register value: move toward the head bit, fill with zero.
    always_comb begin
        shiftNext_s = shiftReg_r;
        head_s      = 1'b0;
        if (MSB_FIRST) begin
            shiftNext_s = {shiftReg_r[WIDTH-2:0], 1'b0};
            head_s      = shiftReg_r[WIDTH-1];
        end else begin
            shiftNext_s = {1'b0, shiftReg_r[WIDTH-1:1]};
            head_s      = shiftReg_r[0];
        end
    end

    // FSM, shift register, bit counter and Done pulse.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_r    <= ST_IDLE;
            shiftReg_r <= '0;
            bitCnt_r   <= '0;
            done_r     <= 1'b0;
`ifdef PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Load) begin
                        shiftReg_r <= ParallelIn;
                        bitCnt_r   <= '0;
                        state_r    <= ST_SHIFT;
`ifdef PARITY_EN
                        parity_r   <= ^ParallelIn;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (ShiftEn) begin
                        shiftReg_r <= shiftNext_s;
                        if (bitCnt_r == LAST_CNT) begin
                            bitCnt_r <= '0;
`ifdef PARITY_EN
                            state_r  <= ST_PARITY;
`else
                            state_r  <= ST_IDLE;
                            done_r   <= 1'b1;
`endif
                        end else begin
                            bitCnt_r <= bitCnt_r + CW'(1);
                        end
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    if (ShiftEn) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_PARITY;
                    end
                end
`endif
                default: begin
                    state_r    <= ST_IDLE;
                    shiftReg_r <= '0;
                    bitCnt_r   <= '0;
                end
            endcase
        end
    end

    // Line and handshake decode straight from registered state.
    always_comb begin
        ShiftOut = 1'b0;
        case (state_r)
            ST_SHIFT:  ShiftOut = head_s;
`ifdef PARITY_EN
            ST_PARITY: ShiftOut = parity_r;
`endif
            default:   ShiftOut = 1'b0;
        endcase
    end

    assign Ready = (state_r == ST_IDLE);
    assign Busy  = ~Ready;
    assign Done  = done_r;

endmodule

// File: tb/tb_parallel_in_serial_out_tx.sv
// Directed self-checking bench for parallel_in_serial_out_tx with a
// ShiftEn-gated serial-in/parallel-out receiver model as loopback sink.
module tb_parallel_in_serial_out_tx;

    logic       Clk = 1'b0;
    logic       ResetN;
    logic [3:0] ParallelIn;
    logic       Load;
    logic       Ready;
    logic       ShiftEn;
    logic       ShiftOut;
    logic       Busy;
    logic       Done;
    logic [3:0] rxWord;

    int passCnt  = 0;
    int totalCnt = 0;

    parallel_in_serial_out_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .ParallelIn(ParallelIn),
        .Load      (Load),
        .Ready     (Ready),
        .ShiftEn   (ShiftEn),
        .ShiftOut  (ShiftOut),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    // Receiver: shifts in at bit 0 on each enabled edge.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) rxWord <= 4'd0;
        else if (ShiftEn) rxWord <= {rxWord[2:0], ShiftOut};
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; Load = 1'b1; ShiftEn = 1'b1; ParallelIn = 4'b1010;
        step(); step();
        totalCnt++; if ({Ready, Busy, ShiftOut, Done} !== 4'b1000)
            $display("FAIL reset_outputs: got RBSD=%b expected 1000", {Ready, Busy, ShiftOut, Done});
        else passCnt++;
        Load = 1'b0; ShiftEn = 1'b0;
        ResetN = 1'b1;
        step();
        totalCnt++; if ({Ready, Busy, ShiftOut, Done} !== 4'b1000)
            $display("FAIL reset_release: got RBSD=%b expected 1000", {Ready, Busy, ShiftOut, Done});
        else passCnt++;
    endtask

    task automatic test_loopback();
        logic [3:0] w;
        w = 4'b1011;
        ParallelIn = w; Load = 1'b1;
        step();
        Load = 1'b0; ShiftEn = 1'b1;
        totalCnt++; if (Busy !== 1'b1 || Ready !== 1'b0)
            $display("FAIL loop_busy: got Busy=%b Ready=%b expected 1 0", Busy, Ready);
        else passCnt++;
        for (int i = 0; i < 4; i++) begin
            totalCnt++; if (ShiftOut !== w[3-i] || Done !== 1'b0)
                $display("FAIL loop_bit%0d: got ShiftOut=%b Done=%b expected %b 0", i, ShiftOut, Done, w[3-i]);
            else passCnt++;
            step();
        end
        totalCnt++; if (Done !== 1'b1 || Ready !== 1'b1 || ShiftOut !== 1'b0)
            $display("FAIL loop_done: got Done=%b Ready=%b ShiftOut=%b expected 1 1 0", Done, Ready, ShiftOut);
        else passCnt++;
        totalCnt++; if (rxWord !== w)
            $display("FAIL loop_rx: got %b expected %b", rxWord, w);
        else passCnt++;
        ShiftEn = 1'b0;
        step();
        totalCnt++; if (Done !== 1'b0)
            $display("FAIL loop_done_pulse: got Done=%b expected 0", Done);
        else passCnt++;
    endtask

    task automatic test_gaps_ignore();
        logic [3:0] w;
        int k;
        w = 4'b0110; k = 0;
        ParallelIn = w; Load = 1'b1;
        step();
        Load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ShiftEn    = (i % 3 == 2);
            Load       = (i == 4);
            ParallelIn = (i >= 4) ? 4'b1111 : w;
            totalCnt++; if (Ready !== 1'b0)
                $display("FAIL gap_ready_c%0d: got Ready=%b expected 0", i, Ready);
            else passCnt++;
            if (ShiftEn) begin
                totalCnt++; if (ShiftOut !== w[3-k])
                    $display("FAIL gap_bit%0d: got ShiftOut=%b expected %b", k, ShiftOut, w[3-k]);
                else passCnt++;
                k++;
            end
            step();
        end
        Load = 1'b0; ShiftEn = 1'b0; ParallelIn = 4'b0000;
        totalCnt++; if (Done !== 1'b1 || rxWord !== w)
            $display("FAIL gap_end: got Done=%b rx=%b expected 1 %b", Done, rxWord, w);
        else passCnt++;
        step();
        totalCnt++; if (Busy !== 1'b0)
            $display("FAIL gap_no_queue: got Busy=%b expected 0", Busy);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int k, idle;
        exp = 8'b1000_0001; k = 0; idle = 0;
        ShiftEn = 1'b1; ParallelIn = 4'b1000; Load = 1'b1;
        step();
        Load = 1'b0;
        for (int c = 0; c < 20 && k < 8; c++) begin
            Load = 1'b0;
            if (Busy) begin
                totalCnt++; if (ShiftOut !== exp[7-k])
                    $display("FAIL b2b_bit%0d: got ShiftOut=%b expected %b", k, ShiftOut, exp[7-k]);
                else passCnt++;
                k++;
            end else begin
                idle++;
            end
            if (Done) begin
                Load = 1'b1; ParallelIn = 4'b0001;
            end
            step();
        end
        Load = 1'b0; ShiftEn = 1'b0;
        totalCnt++; if (k !== 8 || idle !== 1)
            $display("FAIL b2b_contiguous: got bits=%0d idle=%0d expected 8 1", k, idle);
        else passCnt++;
        totalCnt++; if (Done !== 1'b1 || rxWord !== 4'b0001)
            $display("FAIL b2b_end: got Done=%b rx=%b expected 1 0001", Done, rxWord);
        else passCnt++;
        step();
    endtask

    task automatic test_reset_midword();
        logic [3:0] w;
        int seenDone;
        seenDone = 0;
        ParallelIn = 4'b1100; Load = 1'b1;
        step();
        Load = 1'b0; ShiftEn = 1'b1;
        step(); step();
        totalCnt++; if (Busy !== 1'b1)
            $display("FAIL mid_busy: got Busy=%b expected 1", Busy);
        else passCnt++;
        #2 ResetN = 1'b0;
        #1;
        totalCnt++; if ({Ready, Busy, ShiftOut, Done} !== 4'b1000)
            $display("FAIL mid_reset: got RBSD=%b expected 1000", {Ready, Busy, ShiftOut, Done});
        else passCnt++;
        step();
        ResetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (Done !== 1'b0 || Busy !== 1'b0) seenDone++;
        end
        totalCnt++; if (seenDone !== 0)
            $display("FAIL mid_no_done: got %0d active cycles expected 0", seenDone);
        else passCnt++;
        w = 4'b0011;
        ShiftEn = 1'b0; ParallelIn = w; Load = 1'b1;
        step();
        Load = 1'b0; ShiftEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            totalCnt++; if (ShiftOut !== w[3-i])
                $display("FAIL mid_next_bit%0d: got ShiftOut=%b expected %b", i, ShiftOut, w[3-i]);
            else passCnt++;
            step();
        end
        ShiftEn = 1'b0;
        totalCnt++; if (Done !== 1'b1 || rxWord !== w)
            $display("FAIL mid_next_end: got Done=%b rx=%b expected 1 %b", Done, rxWord, w);
        else passCnt++;
        step();
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        logic [4:0] f;
        for (int n = 0; n < 2; n++) begin
            f = (n == 0) ? 5'b0111_1 : 5'b0101_0;
            ParallelIn = f[4:1]; Load = 1'b1; ShiftEn = 1'b0;
            step();
            Load = 1'b0; ShiftEn = 1'b1;
            for (int i = 0; i < 5; i++) begin
                totalCnt++; if (ShiftOut !== f[4-i] || Done !== 1'b0)
                    $display("FAIL par%0d_bit%0d: got ShiftOut=%b Done=%b expected %b 0", n, i, ShiftOut, Done, f[4-i]);
                else passCnt++;
                step();
            end
            ShiftEn = 1'b0;
            totalCnt++; if (Done !== 1'b1)
                $display("FAIL par%0d_done: got Done=%b expected 1", n, Done);
            else passCnt++;
            step();
        end
    endtask
`endif

    initial begin
        ResetN = 1'b0; Load = 1'b0; ShiftEn = 1'b0; ParallelIn = 4'd0;
        #2;
        test_reset();
        test_loopback();
        test_gaps_ignore();
        test_back_to_back();
        test_reset_midword();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
